// File: rtl/axis_hdr_pkg.sv
// Shared types and helpers for the AXI-Stream header inserter: FSM encoding,
// byte popcount and aligned keep-mask builders (sized for up to MAX_BYTES lanes).
package axis_hdr_pkg;

    localparam int MAX_BYTES = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    function automatic logic [7:0] popcount(input logic [MAX_BYTES-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    // n ones packed against the top of an nbytes-wide keep (byte 0 = MSB lane)
    function automatic logic [MAX_BYTES-1:0] hi_keep(input int n, input int nbytes);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i < nbytes) && (i >= nbytes - n);
        end
        return m;
    endfunction

    function automatic logic [MAX_BYTES-1:0] lo_keep(input int n, input int nbytes);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i < nbytes) && (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_stream_insert_header_gen_if.sv
// Bundle of the data, header and output valid/ready links of the header inserter.
interface axi_stream_insert_header_gen_if #(
    parameter int DATA_WD = 32
);
    localparam int BYTES  = DATA_WD / 8;
    localparam int CNT_WD = $clog2(BYTES) + 1;

    logic               valid_in;
    logic [DATA_WD-1:0] data_in;
    logic [BYTES-1:0]   keep_in;
    logic               last_in;
    logic               ready_in;

    logic               valid_insert;
    logic [DATA_WD-1:0] data_insert;
    logic [BYTES-1:0]   keep_insert;
    logic [CNT_WD-1:0]  byte_insert_cnt;
    logic               ready_insert;

    logic               valid_out;
    logic [DATA_WD-1:0] data_out;
    logic [BYTES-1:0]   keep_out;
    logic               last_out;
    logic               ready_out;

    logic               hdr_err;

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_out,
        output ready_in, ready_insert,
        output valid_out, data_out, keep_out, last_out, hdr_err
    );

    modport master (
        output valid_in, data_in, keep_in, last_in,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_out,
        input  ready_in, ready_insert,
        input  valid_out, data_out, keep_out, last_out, hdr_err
    );

endinterface

// File: rtl/axis_byte_merge.sv
// Combinational byte re-packer: splices the held residue in front of an incoming
// beat, returns the leftover bottom bytes and the keep/overflow for a last beat.
module axis_byte_merge
    import axis_hdr_pkg::*;
#(
    parameter  int DATA_WD = 32,
    localparam int BYTES   = DATA_WD / 8,
    localparam int CNT_WD  = $clog2(BYTES) + 1
) (
    input  logic [DATA_WD-1:0] residue_i,
    input  logic [DATA_WD-1:0] data_i,
    input  logic [BYTES-1:0]   keep_i,
    input  logic [CNT_WD-1:0]  h_i,
    output logic [DATA_WD-1:0] merged_o,
    output logic [DATA_WD-1:0] residue_o,
    output logic [BYTES-1:0]   keep_o,
    output logic [CNT_WD:0]    total_o,
    output logic               overflow_o
);

    localparam logic [CNT_WD:0] FULL_T = (CNT_WD + 1)'(BYTES);

    logic [DATA_WD-1:0] in_mask;
    logic [DATA_WD-1:0] out_mask;
    logic [DATA_WD-1:0] data_m;
    logic [CNT_WD-1:0]  k_cnt;
    logic [CNT_WD-1:0]  h_comp;

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_mask
            assign in_mask[8*gi +: 8]  = {8{keep_i[gi]}};
            assign out_mask[8*gi +: 8] = {8{keep_o[gi]}};
        end
    endgenerate

    // Disabled input lanes are zeroed so they never leak into output or residue
    assign data_m     = data_i & in_mask;
    assign k_cnt      = CNT_WD'(popcount(MAX_BYTES'(keep_i)));
    assign h_comp     = CNT_WD'(BYTES) - h_i;
    assign total_o    = {1'b0, h_i} + {1'b0, k_cnt};
    assign overflow_o = total_o > FULL_T;
    assign keep_o     = overflow_o ? '1 : BYTES'(hi_keep(int'(total_o), BYTES));

    // Residue is kept high-aligned with zero low lanes, so OR is a splice
    assign merged_o   = (residue_i | (data_m >> {h_i, 3'b000})) & out_mask;
    assign residue_o  = data_m << {h_comp, 3'b000};

endmodule

// File: rtl/axi_stream_insert_header_gen.sv
// Header inserter top: packet FSM, header residue register and a single output
// register stage that supports full throughput and holds steady under backpressure.
module axi_stream_insert_header_gen
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axi_stream_insert_header_gen_if.slave bus
);

    localparam int BYTES  = DATA_WD / 8;
    localparam int CNT_WD = $clog2(BYTES) + 1;

    state_e             state_q, state_d;
    logic [CNT_WD-1:0]  h_q, h_d;
    logic [DATA_WD-1:0] residue_q, residue_d;
    logic [BYTES-1:0]   flush_keep_q, flush_keep_d;
    logic               valid_out_q, valid_out_d;
    logic [DATA_WD-1:0] data_out_q, data_out_d;
    logic [BYTES-1:0]   keep_out_q, keep_out_d;
    logic               last_out_q, last_out_d;
    logic               hdr_err_q, hdr_err_d;

    logic               ready_in_c;
    logic               ready_insert_c;
    logic               out_free;
    logic [CNT_WD-1:0]  hdr_h;
    logic [CNT_WD-1:0]  hdr_hc;

    logic [DATA_WD-1:0] m_merged;
    logic [DATA_WD-1:0] m_residue;
    logic [BYTES-1:0]   m_keep;
    logic [CNT_WD:0]    m_total;
    logic               m_overflow;

    axis_byte_merge #(.DATA_WD(DATA_WD)) u_merge (
        .residue_i  (residue_q),
        .data_i     (bus.data_in),
        .keep_i     (bus.keep_in),
        .h_i        (h_q),
        .merged_o   (m_merged),
        .residue_o  (m_residue),
        .keep_o     (m_keep),
        .total_o    (m_total),
        .overflow_o (m_overflow)
    );

    // keep_insert is authoritative for the header length; the count is only checked
    assign hdr_h  = CNT_WD'(popcount(MAX_BYTES'(bus.keep_insert)));
    assign hdr_hc = CNT_WD'(BYTES) - hdr_h;
    assign out_free = !valid_out_q || bus.ready_out;

    always_comb begin
        state_d        = state_q;
        h_d            = h_q;
        residue_d      = residue_q;
        flush_keep_d   = flush_keep_q;
        valid_out_d    = valid_out_q;
        data_out_d     = data_out_q;
        keep_out_d     = keep_out_q;
        last_out_d     = last_out_q;
        hdr_err_d      = 1'b0;
        ready_in_c     = 1'b0;
        ready_insert_c = 1'b0;

        if (valid_out_q && bus.ready_out) begin
            valid_out_d = 1'b0;
            data_out_d  = '0;
            keep_out_d  = '0;
            last_out_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                ready_insert_c = 1'b1;
                if (bus.valid_insert) begin
                    h_d       = hdr_h;
                    residue_d = bus.data_insert << {hdr_hc, 3'b000};
                    hdr_err_d = (bus.byte_insert_cnt != hdr_h);
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                ready_in_c = out_free;
                if (bus.valid_in && out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = m_merged;
                    keep_out_d  = m_keep;
                    last_out_d  = bus.last_in && !m_overflow;
                    residue_d   = m_residue;
                    if (bus.last_in) begin
                        if (m_overflow) begin
                            flush_keep_d = BYTES'(hi_keep(int'(m_total) - BYTES, BYTES));
                            state_d      = ST_FLUSH;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                // last_out_q marks that the flush beat already sits in the output register
                if (valid_out_q && last_out_q) begin
                    if (bus.ready_out) begin
                        state_d = ST_IDLE;
                    end
                end else if (out_free) begin
                    valid_out_d = 1'b1;
                    data_out_d  = residue_q;
                    keep_out_d  = flush_keep_q;
                    last_out_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            h_q          <= '0;
            residue_q    <= '0;
            flush_keep_q <= '0;
            valid_out_q  <= 1'b0;
            data_out_q   <= '0;
            keep_out_q   <= '0;
            last_out_q   <= 1'b0;
            hdr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            residue_q    <= residue_d;
            flush_keep_q <= flush_keep_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            keep_out_q   <= keep_out_d;
            last_out_q   <= last_out_d;
            hdr_err_q    <= hdr_err_d;
        end
    end

    assign bus.ready_in     = ready_in_c;
    assign bus.ready_insert = ready_insert_c;
    assign bus.valid_out    = valid_out_q;
    assign bus.data_out     = data_out_q;
    assign bus.keep_out     = keep_out_q;
    assign bus.last_out     = last_out_q;
    assign bus.hdr_err      = hdr_err_q;

endmodule
